// File: rtl/arb_pkg.sv
// Shared types, widths and the reference round-robin pick for the 8-way arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set bit of mask scanning start, start+1, ... with wrap from N_REQ-1 to 0.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                                 input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] idx;
        rr_pick = start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = start + IDX_W'(i);
            if (mask[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/decoder_3_8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module decoder_3_8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y
);

    assign y = en ? (8'b1 << a) : 8'h00;

endmodule

// File: rtl/rr_pick_8.sv
// Round-robin pick: rotate mask so start sits at bit 0, priority-encode, rotate back.
module rr_pick_8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    always_comb begin
        rot = N_REQ'({mask, mask} >> start);
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IDX_W'(i);
        end
        idx = start + off;
        any = |mask;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with hold timeout; owner index is registered and
// expanded to a one-hot grant through decoder_3_8.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic             preempt_n;

    logic [IDX_W-1:0] owner_inc;
    logic [IDX_W-1:0] all_start;
    logic [N_REQ-1:0] others;
    logic [IDX_W-1:0] all_idx, oth_idx;
    logic             all_any, oth_any;

    assign owner_inc = owner + IDX_W'(1);
    assign others    = req & ~(N_REQ'(1) << owner);
    // Idle scans from the fairness pointer; a releasing owner hands over starting after itself.
    assign all_start = (state == GRANT) ? owner_inc : ptr;

    rr_pick_8 u_pick_all (
        .mask  (req),
        .start (all_start),
        .idx   (all_idx),
        .any   (all_any)
    );

    rr_pick_8 u_pick_oth (
        .mask  (others),
        .start (owner_inc),
        .idx   (oth_idx),
        .any   (oth_any)
    );

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        preempt_n = 1'b0;
        case (state)
            IDLE: begin
                if (all_any) begin
                    state_n = GRANT;
                    owner_n = all_idx;
                    hold_n  = '0;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    ptr_n  = owner_inc;
                    hold_n = '0;
                    if (oth_any) owner_n = all_idx;
                    else         state_n = IDLE;
                end else if (hold_cnt == HOLD_LAST) begin
                    hold_n = '0;
                    if (oth_any) begin
                        ptr_n     = owner_inc;
                        owner_n   = oth_idx;
                        preempt_n = 1'b1;
                    end
                end else begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            preempt  <= preempt_n;
        end
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_idx   = owner;

    decoder_3_8 u_dec (
        .en (gnt_valid),
        .a  (owner),
        .y  (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 with hand-computed expectations.
module tb_rr_arbiter_8;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_assert = 0;
    int n_fail   = 0;

    rr_arbiter_8 #(.MAX_HOLD(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = 8'h00;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'hFF;

        // 1: reset holds everything idle even with all requests up
        step();
        step();
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_valid", {7'b0, gnt_valid}, 8'h00);
        chk("rst_idx", {5'b0, gnt_idx}, 8'h00);
        chk("rst_preempt", {7'b0, preempt}, 8'h00);
        reset = 1'b0;
        req   = 8'h01;
        step();
        chk("t1_gnt", gnt, 8'h01);
        chk("t1_idx", {5'b0, gnt_idx}, 8'h00);
        chk("t1_valid", {7'b0, gnt_valid}, 8'h01);

        // 2: hand-over without an idle cycle
        apply_reset();
        req = 8'h05;
        step();
        chk("t2_first", gnt, 8'h01);
        step();
        chk("t2_hold", gnt, 8'h01);
        req = 8'h04;
        step();
        chk("t2_handover", gnt, 8'h04);
        chk("t2_handover_valid", {7'b0, gnt_valid}, 8'h01);
        chk("t2_no_preempt", {7'b0, preempt}, 8'h00);
        req = 8'h01;
        step();
        chk("t2_back", gnt, 8'h01);

        // 3: full rotation under constant load, 16 cycles per owner
        apply_reset();
        req = 8'hFF;
        step();
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 16; j++) begin
                if (k != 0 || j != 0) step();
                chk($sformatf("t3_gnt_k%0d_j%0d", k, j), gnt, 8'(8'h01 << (k % 8)));
                chk($sformatf("t3_pre_k%0d_j%0d", k, j), {7'b0, preempt},
                    (j == 0 && k > 0) ? 8'h01 : 8'h00);
            end
        end
        chk("t3_idx_end", {5'b0, gnt_idx}, 8'h00);

        // 4: lone owner keeps the grant forever, then idles
        apply_reset();
        req = 8'h08;
        for (int c = 0; c < 40; c++) begin
            step();
            chk($sformatf("t4_gnt_c%0d", c), gnt, 8'h08);
            chk($sformatf("t4_pre_c%0d", c), {7'b0, preempt}, 8'h00);
        end
        req = 8'h00;
        step();
        chk("t4_idle_gnt", gnt, 8'h00);
        chk("t4_idle_valid", {7'b0, gnt_valid}, 8'h00);
        // pointer now sits after owner 3
        req = 8'h21;
        step();
        chk("t4_ptr_pick", gnt, 8'h20);
        chk("t4_ptr_idx", {5'b0, gnt_idx}, 8'h05);

        // 5: wrap-around scans
        apply_reset();
        req = 8'h80;
        step();
        chk("t5_own7", gnt, 8'h80);
        req = 8'h81;
        step();
        chk("t5_own7_hold", gnt, 8'h80);
        req = 8'h01;
        step();
        chk("t5_wrap7", gnt, 8'h01);
        apply_reset();
        req = 8'h40;
        step();
        chk("t5_own6", gnt, 8'h40);
        req = 8'h41;
        step();
        chk("t5_own6_hold", gnt, 8'h40);
        req = 8'h01;
        step();
        chk("t5_wrap6", gnt, 8'h01);
        apply_reset();
        req = 8'hC3;
        step();
        chk("t5_c3_first", gnt, 8'h01);
        req = 8'hC2;
        step();
        chk("t5_c3_next", gnt, 8'h02);
        req = 8'hC0;
        step();
        chk("t5_c3_skip", gnt, 8'h40);
        req = 8'h83;
        step();
        chk("t5_c3_seven", gnt, 8'h80);

        // 6: async reset mid-grant
        apply_reset();
        req = 8'h10;
        step();
        chk("t6_own4", gnt, 8'h10);
        reset = 1'b1;
        #1;
        chk("t6_async_gnt", gnt, 8'h00);
        chk("t6_async_valid", {7'b0, gnt_valid}, 8'h00);
        step();
        reset = 1'b0;
        req   = 8'h11;
        step();
        chk("t6_after", gnt, 8'h01);
        chk("t6_after_idx", {5'b0, gnt_idx}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
